// File: rtl/sample_timer_ctrl_if.sv
// Sample handshake between the timer controller (master) and the I2C read sequencer (slave).
// smp_req stays high while a reading is wanted; the slave answers with a one-cycle smp_ack
// and presents smp_data in that same cycle; an ack while smp_req is low carries no data.
interface sample_timer_ctrl_if #(
   parameter int DATA_W = 12
);
   logic              smp_req;
   logic              smp_ack;
   logic [DATA_W-1:0] smp_data;

   modport master (output smp_req, input smp_ack, input smp_data);
   modport slave  (input smp_req, output smp_ack, output smp_data);
endinterface

// File: rtl/sample_timer_ctrl.sv
// Periodic temperature sampler: reloads an external 8-bit counter chain, requests a reading
// when it carries out, captures the value with hysteresis alarm and a bounded ack wait.
module sample_timer_ctrl #(
   parameter int DATA_W  = 12,
   parameter int TIMEOUT = 64
) (
   input  logic                CLK,
   input  logic                CLR_n,
   input  logic                en,
   input  logic [7:0]          period,
   input  logic                cnt_rco,
   output logic [7:0]          cnt_d,
   output logic                cnt_load_n,
   output logic                cnt_enp,
   output logic                cnt_ent,
   sample_timer_ctrl_if.master smp,
   input  logic [DATA_W-1:0]   th_hi,
   input  logic [DATA_W-1:0]   th_lo,
   output logic [DATA_W-1:0]   temp_out,
   output logic                temp_valid,
   output logic                alarm,
   output logic                err_timeout,
   input  logic                err_clr,
   output logic [1:0]          state_dbg
);
   // state_dbg encoding: 0 IDLE, 1 LOAD, 2 COUNT, 3 WAIT
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COUNT = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_nx;
   logic [7:0]        wcnt, wcnt_nx;
   logic [7:0]        cnt_d_nx;
   logic              load_n_nx;
   logic              cnt_en_nx;
   logic              req_nx;
   logic [DATA_W-1:0] temp_nx;
   logic              valid_nx;
   logic              alarm_nx;
   logic              err_nx;
   logic              done;

   // Every output is the registered image of its *_nx value, so each branch below sets
   // what the outputs must look like during the state being entered.
   always_comb begin
      state_nx  = state;
      wcnt_nx   = wcnt;
      cnt_d_nx  = cnt_d;
      load_n_nx = 1'b1;
      cnt_en_nx = 1'b0;
      req_nx    = 1'b0;
      temp_nx   = temp_out;
      valid_nx  = 1'b0;
      alarm_nx  = alarm;
      err_nx    = err_timeout & ~err_clr;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (en) begin
               state_nx  = S_LOAD;
               load_n_nx = 1'b0;
               cnt_d_nx  = period;
            end
         end
         S_LOAD: begin
            state_nx  = S_COUNT;
            cnt_en_nx = 1'b1;
         end
         S_COUNT: begin
            if (cnt_rco) begin
               state_nx = S_WAIT;
               req_nx   = 1'b1;
               wcnt_nx  = 8'd0;
            end else if (!en) begin
               state_nx = S_IDLE;
            end else begin
               cnt_en_nx = 1'b1;
            end
         end
         S_WAIT: begin
            // An ack on the last allowed cycle still wins over the timeout.
            if (smp.smp_ack) begin
               temp_nx  = smp.smp_data;
               valid_nx = 1'b1;
               if (smp.smp_data >= th_hi)      alarm_nx = 1'b1;
               else if (smp.smp_data <= th_lo) alarm_nx = 1'b0;
               done = 1'b1;
            end else if (wcnt == WAIT_LAST) begin
               err_nx = 1'b1;
               done   = 1'b1;
            end else begin
               wcnt_nx = wcnt + 8'd1;
               req_nx  = 1'b1;
            end
            if (done) begin
               if (en) begin
                  state_nx  = S_LOAD;
                  load_n_nx = 1'b0;
                  cnt_d_nx  = period;
               end else begin
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         state       <= S_IDLE;
         wcnt        <= 8'd0;
         cnt_d       <= 8'd0;
         cnt_load_n  <= 1'b1;
         cnt_enp     <= 1'b0;
         cnt_ent     <= 1'b0;
         smp.smp_req <= 1'b0;
         temp_out    <= '0;
         temp_valid  <= 1'b0;
         alarm       <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_nx;
         wcnt        <= wcnt_nx;
         cnt_d       <= cnt_d_nx;
         cnt_load_n  <= load_n_nx;
         cnt_enp     <= cnt_en_nx;
         cnt_ent     <= cnt_en_nx;
         smp.smp_req <= req_nx;
         temp_out    <= temp_nx;
         temp_valid  <= valid_nx;
         alarm       <= alarm_nx;
         err_timeout <= err_nx;
      end
   end

   assign state_dbg = state;
endmodule

// File: tb/tb_sample_timer_ctrl.sv
// Bench for sample_timer_ctrl wired to two cascaded 4-bit loadable counters, with a
// transaction-level reference model compared every cycle plus hand-computed pins.
module tb_sample_timer_ctrl;
   localparam int DW  = 12;
   localparam int TMO = 16;

   logic          CLK     = 1'b0;
   logic          CLR_n   = 1'b1;
   logic          en      = 1'b0;
   logic          err_clr = 1'b0;
   logic [7:0]    period  = 8'hFC;
   logic [DW-1:0] th_hi   = 12'h200;
   logic [DW-1:0] th_lo   = 12'h1C0;
   logic [7:0]    cnt_d;
   logic          cnt_load_n, cnt_enp, cnt_ent, cnt_rco;
   logic [DW-1:0] temp_out;
   logic          temp_valid, alarm, err_timeout;
   logic [1:0]    state_dbg;

   sample_timer_ctrl_if #(.DATA_W(DW)) sif ();

   sample_timer_ctrl #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .CLR_n(CLR_n), .en(en), .period(period), .cnt_rco(cnt_rco),
      .cnt_d(cnt_d), .cnt_load_n(cnt_load_n), .cnt_enp(cnt_enp), .cnt_ent(cnt_ent),
      .smp(sif.master), .th_hi(th_hi), .th_lo(th_lo), .temp_out(temp_out),
      .temp_valid(temp_valid), .alarm(alarm), .err_timeout(err_timeout),
      .err_clr(err_clr), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;
   initial #1 CLR_n = 1'b0;

   // ---------------- external counter chain (163-style stages) ----------------
   logic [3:0] q_lo = 4'h0;
   logic [3:0] q_hi = 4'h0;
   wire        rco_lo = cnt_ent & (q_lo == 4'hF);
   assign cnt_rco = rco_lo & (q_hi == 4'hF);
   always @(posedge CLK) begin
      if (!cnt_load_n) begin
         q_lo <= cnt_d[3:0];
         q_hi <= cnt_d[7:4];
      end else begin
         if (cnt_enp && cnt_ent) q_lo <= q_lo + 4'd1;
         if (cnt_enp && rco_lo)  q_hi <= q_hi + 4'd1;
      end
   end

   // ---------------- reference model ----------------
   // m_run: COUNT cycles still to go (256 - reload value when a run starts);
   // m_age: cycles already spent waiting for an ack, -1 when no request is open.
   logic [7:0]    m_cnt_d = 8'h00;
   bit            m_load  = 1'b0;
   int            m_run   = 0;
   int            m_age   = -1;
   logic [DW-1:0] m_temp  = '0;
   bit            m_valid = 1'b0;
   bit            m_alarm = 1'b0;
   bit            m_err   = 1'b0;
   logic [DW-1:0] exp_q[$];

   task automatic model_reset();
      m_cnt_d = 8'h00; m_load = 1'b0; m_run = 0; m_age = -1;
      m_temp = '0; m_valid = 1'b0; m_alarm = 1'b0; m_err = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_step();
      bit finish, start, n_valid, n_err;
      int n_run, n_age;
      finish = 1'b0; start = 1'b0; n_valid = 1'b0;
      n_run = 0; n_age = -1;
      n_err = m_err && !err_clr;
      if (m_age >= 0) begin
         if (sif.smp_ack === 1'b1) begin
            m_temp  = sif.smp_data;
            n_valid = 1'b1;
            exp_q.push_back(sif.smp_data);
            if (sif.smp_data >= th_hi)      m_alarm = 1'b1;
            else if (sif.smp_data <= th_lo) m_alarm = 1'b0;
            finish = 1'b1;
         end else if (m_age == TMO - 1) begin
            n_err  = 1'b1;
            finish = 1'b1;
         end else begin
            n_age = m_age + 1;
         end
         start = finish && en;
      end else if (m_load) begin
         n_run = 256 - int'(m_cnt_d);
      end else if (m_run > 0) begin
         if (m_run == 1)  n_age = 0;
         else if (en)     n_run = m_run - 1;
      end else begin
         start = en;
      end
      if (start) m_cnt_d = period;
      m_load = start; m_run = n_run; m_age = n_age; m_err = n_err; m_valid = n_valid;
   endtask

   always @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) model_reset();
      else        model_step();
   end

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_pass = 0;
   bit ck_on  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge CLK) begin
      if (ck_on) begin
         check("load_n",      32'(cnt_load_n),  32'(!m_load));
         check("enp",         32'(cnt_enp),     32'(m_run > 0));
         check("ent",         32'(cnt_ent),     32'(m_run > 0));
         check("cnt_d",       32'(cnt_d),       32'(m_cnt_d));
         check("smp_req",     32'(sif.smp_req), 32'(m_age >= 0));
         check("temp_out",    32'(temp_out),    32'(m_temp));
         check("temp_valid",  32'(temp_valid),  32'(m_valid));
         check("alarm",       32'(alarm),       32'(m_alarm));
         check("err_timeout", 32'(err_timeout), 32'(m_err));
         if (temp_valid === 1'b1) begin
            check("sb_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("sb_temp", 32'(temp_out), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (sif.smp_req !== 1'b1 && n < 600) begin
         @(negedge CLK);
         n++;
      end
      if (sif.smp_req !== 1'b1) check(name, 32'(sif.smp_req), 1);
   endtask

   task automatic wait_load(output int n);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (cnt_load_n !== 1'b0 && n < 600);
   endtask

   // Answers the next request after 'delay' waiting cycles; returns on the capture-result cycle.
   task automatic ack_next(input logic [DW-1:0] d, input int delay);
      wait_req("ack_req_wait");
      repeat (delay) @(negedge CLK);
      sif.smp_ack  = 1'b1;
      sif.smp_data = d;
      @(negedge CLK);
      sif.smp_ack = 1'b0;
   endtask

   // ---------------- directed + random stimulus ----------------
   logic [DW-1:0] alarm_vals [3] = '{12'h200, 12'h1E0, 12'h1C0};
   bit            alarm_exp  [3] = '{1'b1, 1'b1, 1'b0};

   initial begin
      int n, n_en, loads, age, ack_at;
      bit seen_valid, in_wait;
      sif.smp_ack  = 1'b0;
      sif.smp_data = '0;
      repeat (2) @(negedge CLK);
      ck_on = 1'b1;
      check("rst_temp_out", 32'(temp_out), 0);
      check("rst_load_n",   32'(cnt_load_n), 1);
      #2 CLR_n = 1'b1;

      // Reload FC: one LOAD cycle, four COUNT cycles, then the request.
      @(negedge CLK);
      en = 1'b1;
      wait_load(n);
      check("first_load_lat", n, 1);
      check("load_cnt_d", 32'(cnt_d), 32'hFC);
      n = 0; n_en = 0;
      while (sif.smp_req !== 1'b1 && n < 600) begin
         @(negedge CLK);
         n++;
         if (n == 1) check("load_one_cycle", 32'(cnt_load_n), 1);
         if (cnt_enp === 1'b1) n_en++;
      end
      check("req_after_load", n, 5);
      check("count_cycles", n_en, 4);

      // Ack in the fourth waiting cycle with 190.
      repeat (3) @(negedge CLK);
      sif.smp_ack = 1'b1; sif.smp_data = 12'h190;
      @(negedge CLK);
      sif.smp_ack = 1'b0;
      check("cap_temp",   32'(temp_out), 32'h190);
      check("cap_valid",  32'(temp_valid), 1);
      check("cap_req",    32'(sif.smp_req), 0);
      check("cap_reload", 32'(cnt_load_n), 0);
      @(negedge CLK);
      check("cap_valid_pulse", 32'(temp_valid), 0);

      // Hysteresis: 200 sets, 1E0 holds, 1C0 clears.
      for (int i = 0; i < 3; i++) begin
         ack_next(alarm_vals[i], 2);
         check("hyst_valid", 32'(temp_valid), 1);
         check("hyst_alarm", 32'(alarm), 32'(alarm_exp[i]));
      end

      // No ack: request held for TMO cycles, then sticky error.
      wait_req("tmo_req_wait");
      n = 0; seen_valid = 1'b0;
      while (sif.smp_req === 1'b1 && n < 40) begin
         n++;
         @(negedge CLK);
         seen_valid = seen_valid | (temp_valid === 1'b1);
      end
      check("tmo_req_cycles", n, TMO);
      check("tmo_err",        32'(err_timeout), 1);
      check("tmo_no_valid",   32'(seen_valid), 0);
      check("tmo_temp_kept",  32'(temp_out), 32'h1C0);
      err_clr = 1'b1;
      @(negedge CLK);
      err_clr = 1'b0;
      check("err_clr", 32'(err_timeout), 0);

      // en dropped while waiting: the ack still completes, then the controller rests.
      wait_req("drop_req_wait");
      en = 1'b0;
      repeat (5) @(negedge CLK);
      sif.smp_ack = 1'b1; sif.smp_data = 12'h0A5;
      @(negedge CLK);
      sif.smp_ack = 1'b0;
      check("drop_valid",  32'(temp_valid), 1);
      check("drop_temp",   32'(temp_out), 32'h0A5);
      check("drop_load_n", 32'(cnt_load_n), 1);
      loads = 0;
      repeat (300) begin
         @(negedge CLK);
         if (cnt_load_n === 1'b0 || cnt_enp === 1'b1) loads++;
      end
      check("drop_idle", loads, 0);
      check("drop_idle_dbg", 32'(state_dbg), 0);

      // Reset mid-wait, with an ack pending: request drops before any clock edge.
      en = 1'b1;
      wait_req("rst_req_wait");
      @(negedge CLK);
      sif.smp_ack = 1'b1; sif.smp_data = 12'hABC;
      #2 CLR_n = 1'b0;
      #1;
      check("arst_req",    32'(sif.smp_req), 0);
      check("arst_temp",   32'(temp_out), 0);
      check("arst_valid",  32'(temp_valid), 0);
      check("arst_load_n", 32'(cnt_load_n), 1);
      check("arst_enp",    32'(cnt_enp), 0);
      check("arst_cnt_d",  32'(cnt_d), 0);
      @(negedge CLK);
      sif.smp_ack = 1'b0;
      #2 CLR_n = 1'b1;
      wait_load(n);
      check("load_after_rst", n, 1);

      // Randomized traffic, including stray acks, en toggles, err_clr and one reset.
      for (int seg = 0; seg < 10; seg++) begin
         en = 1'b0; sif.smp_ack = 1'b0; err_clr = 1'b0;
         repeat (24) @(negedge CLK);
         period = (seg == 3) ? 8'h00 : 8'($urandom_range(8'hE0, 8'hFF));
         th_lo  = DW'($urandom_range(32'h100, 32'h1FF));
         th_hi  = th_lo + DW'($urandom_range(1, 32'h100));
         en = 1'b1;
         in_wait = 1'b0; age = 0; ack_at = 0;
         for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (seg == 5 && c == 150) begin
               #2 CLR_n = 1'b0;
               @(negedge CLK);
               #2 CLR_n = 1'b1;
            end
            sif.smp_ack = 1'b0;
            if (sif.smp_req === 1'b1) begin
               if (!in_wait) begin
                  in_wait = 1'b1; age = 0;
                  ack_at = $urandom_range(0, TMO + 3);
               end else begin
                  age++;
               end
               if (age == ack_at) begin
                  sif.smp_ack  = 1'b1;
                  sif.smp_data = DW'($urandom_range(32'h0C0, 32'h340));
               end
            end else begin
               in_wait = 1'b0;
               if ($urandom_range(0, 15) == 0) begin
                  sif.smp_ack  = 1'b1;
                  sif.smp_data = DW'($urandom_range(32'h0C0, 32'h340));
               end
            end
            if ($urandom_range(0, 99) == 0) en = ~en;
            err_clr = ($urandom_range(0, 31) == 0);
         end
      end

      en = 1'b0; sif.smp_ack = 1'b0; err_clr = 1'b0;
      repeat (40) @(negedge CLK);
      check("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sample_timer_ctrl.md
SAMPLE_TIMER_CTRL -- requirements
Module: sample_timer_ctrl

Interface
REQ-001 Parameter DATA_W, default 12: temperature sample width, bits.
REQ-002 Parameter TIMEOUT, default 64: max WAIT cycles for smp_ack, range 2..255.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 CLR_n  in  1  reset, asynchronous, active-low.
REQ-005 en  in  1  run enable; level-sensitive.
REQ-006 period  in  8  reload value for the external 8-bit counter chain (two cascaded 4-bit loadable counters).
REQ-007 cnt_rco  in  1  terminal-count carry from the upper counter stage.
REQ-008 cnt_d  out  8  parallel load data to the counter chain.
REQ-009 cnt_load_n  out  1  synchronous load strobe, active-low.
REQ-010 cnt_enp  out  1  count enable P to both stages.
REQ-011 cnt_ent  out  1  count enable T to the lower stage.
REQ-012 smp_req  out  1  sample request to the I2C read sequencer.
REQ-013 smp_ack  in  1  single-cycle acknowledge; smp_data valid in the same cycle.
REQ-014 smp_data  in  DATA_W  temperature reading, unsigned.
REQ-015 th_hi, th_lo  in  DATA_W each  alarm set/clear thresholds, th_lo < th_hi.
REQ-016 temp_out  out  DATA_W  last captured reading.
REQ-017 temp_valid  out  1  one-cycle pulse on each new capture.
REQ-018 alarm  out  1  over-temperature flag with hysteresis.
REQ-019 err_timeout  out  1  sticky timeout flag; err_clr (in, 1) clears it.

Function
REQ-020 FSM states IDLE, LOAD, COUNT, WAIT; all outputs registered.
REQ-021 IDLE: cnt_load_n=1, cnt_enp=cnt_ent=0, smp_req=0; en=1 -> LOAD.
REQ-022 LOAD: exactly one cycle, cnt_load_n=0, cnt_d=period sampled that cycle; -> COUNT.
REQ-023 COUNT: cnt_enp=cnt_ent=1; cnt_rco=1 -> WAIT; else en=0 -> IDLE; cnt_rco has priority over en=0.
REQ-024 Period: WAIT entered 256-period cycles after the LOAD cycle; period=8'h00 gives 256 cycles.
REQ-025 WAIT: cnt_enp=cnt_ent=0, smp_req=1; counter chain holds.
REQ-026 WAIT, smp_ack=1: capture smp_data into temp_out at that edge, temp_valid=1 next cycle only, smp_req=0 next cycle; -> LOAD if en=1, else IDLE.
REQ-027 WAIT timeout: 8-bit cycle counter cleared on WAIT entry; no ack within TIMEOUT WAIT cycles -> err_timeout=1, smp_req=0, temp_out unchanged, no temp_valid; -> LOAD if en=1, else IDLE.
REQ-028 smp_ack in the same cycle as timeout expiry: ack wins, no error.
REQ-029 en=0 during WAIT: transaction not abandoned; completes via ack or timeout, then IDLE.
REQ-030 smp_ack outside WAIT: ignored, no capture.
REQ-031 Alarm, evaluated on each capture only: value >= th_hi -> alarm=1; value <= th_lo -> alarm=0; otherwise hold.
REQ-032 err_clr=1 clears err_timeout; a simultaneous timeout takes priority (flag stays 1).
REQ-033 temp_valid and the alarm update occur in the same cycle.

Reset
REQ-034 CLR_n=0 forces state IDLE and, immediately and asynchronously: cnt_d=0, cnt_load_n=1, cnt_enp=cnt_ent=0, smp_req=0, temp_out=0, temp_valid=0, alarm=0, err_timeout=0, timeout counter=0.
REQ-035 Reset during WAIT drops smp_req without waiting for a clock edge; no capture occurs.
REQ-036 After CLR_n release, the first LOAD occurs on the first edge with en=1.

Verification
REQ-037 Bench: DUT plus two cascaded 4-bit loadable counters; period=8'hFC, en=1 -> cnt_load_n low 1 cycle, smp_req rises 4 cycles after the LOAD cycle.
REQ-038 In WAIT, smp_ack after 3 cycles with smp_data=12'h190 -> temp_out=12'h190, temp_valid pulses 1 cycle, smp_req low, next LOAD follows.
REQ-039 th_hi=12'h200, th_lo=12'h1C0; captures 12'h200, 12'h1E0, 12'h1C0 -> alarm 1, 1, 0.
REQ-040 TIMEOUT=16, no ack -> smp_req low after 16 WAIT cycles, err_timeout=1, no temp_valid; err_clr pulse -> err_timeout=0.
REQ-041 en dropped during WAIT, ack at cycle 5 -> capture completes, FSM goes IDLE, no further LOAD.
REQ-042 CLR_n low mid-WAIT -> smp_req=0 before the next edge; all outputs at reset values; no temp_valid.
